inflight_rd_tracker: RTL and testbench

INFLIGHT_RD_TRACKER -- requirements
Module: inflight_rd_tracker

---
 rtl/inflight_rd_tracker_pkg.sv | 13 +
 rtl/inflight_rd_tracker_decode.sv | 15 +
 rtl/inflight_rd_tracker.sv | 102 ++++++++++
 tb/tb_inflight_rd_tracker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/inflight_rd_tracker_pkg.sv
// Shared core definitions for the in-flight destination-register tracker.
package inflight_rd_tracker_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef logic [4:0] rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
  } entry_t;

endpackage

// File: rtl/inflight_rd_tracker_decode.sv
// 5-to-32 one-hot decoder with enable; one instance per tracker entry.
module rd_onehot_decode
  import inflight_rd_tracker_pkg::*;
(
  input  logic        en,
  input  rd_t         rd,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[rd] = 1'b1;
  end

endmodule

// File: rtl/inflight_rd_tracker.sv
// In-order FIFO of in-flight register writers; drives a per-register busy
// vector and a registered release strobe toward the hazard scoreboard.
module inflight_rd_tracker
  import inflight_rd_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  output logic                     issue_ready,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic                     flush,
  input  logic [$clog2(DEPTH):0]   flush_keep,
  output logic                     rel_valid,
  output logic [4:0]               rel_rd,
  output logic [31:0]              busy_vec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow,
  output logic                     err_mismatch
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  rd_t         mem [DEPTH];
  entry_t      ent [DEPTH];
  logic [31:0] dec [DEPTH];
  logic [31:0] busy_acc;

  ptr_t head, tail, head_nx;
  cnt_t cnt, cnt_post, keep_n;
  logic pop, push;
  rd_t  head_rd;

  assign count       = cnt;
  assign issue_ready = (cnt < cnt_t'(DEPTH));

  always_comb begin
    head_rd  = mem[head];
    pop      = wb_valid && (cnt != '0);
    push     = issue_valid && issue_ready && (issue_rd != '0) && !flush;
    head_nx  = head + ptr_t'(pop);
    cnt_post = cnt - cnt_t'(pop);
    keep_n   = (flush_keep < cnt_post) ? flush_keep : cnt_post;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      rel_valid     <= 1'b0;
      rel_rd        <= '0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
    end else begin
      rel_valid <= pop;
      if (pop) rel_rd <= head_rd;
      if (wb_valid && (cnt == '0)) err_underflow <= 1'b1;
      if (pop && (wb_rd != head_rd)) err_mismatch <= 1'b1;
      head <= head_nx;
      // Flush resolves after the pop; keep_n == DEPTH truncates to a full wrap.
      if (flush) begin
        cnt  <= keep_n;
        tail <= head_nx + ptr_t'(keep_n);
      end else begin
        cnt <= cnt_post + cnt_t'(push);
        if (push) tail <= tail + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= issue_rd;
  end

  // An entry is live when its distance from head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    ptr_t off;
    assign off    = ptr_t'(g) - head;
    assign ent[g] = '{valid: (cnt_t'(off) < cnt), rd: mem[g]};

    rd_onehot_decode u_dec (
      .en     (ent[g].valid),
      .rd     (ent[g].rd),
      .onehot (dec[g])
    );
  end

  always_comb begin
    busy_acc = '0;
    for (int unsigned i = 0; i < DEPTH; i++) busy_acc = busy_acc | dec[i];
    busy_vec = {busy_acc[31:1], 1'b0};
  end

endmodule

// File: tb/tb_inflight_rd_tracker.sv
// Directed table-driven bench for inflight_rd_tracker at DEPTH=4.
module tb_inflight_rd_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [2:0]  flush_keep;
  logic        rel_valid;
  logic [4:0]  rel_rd;
  logic [31:0] busy_vec;
  logic [2:0]  count;
  logic        err_underflow;
  logic        err_mismatch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inflight_rd_tracker #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .flush_keep    (flush_keep),
    .rel_valid     (rel_valid),
    .rel_rd        (rel_rd),
    .busy_vec      (busy_vec),
    .count         (count),
    .err_underflow (err_underflow),
    .err_mismatch  (err_mismatch)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wrd;
    logic        fl;
    logic [2:0]  keep;
    logic        rdy;
    logic [2:0]  cnt;
    logic [31:0] busy;
    logic        relv;
    logic [4:0]  relrd;
    logic        uf;
    logic        mm;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int r, int iv, int ird, int wv, int wrd, int fl, int keep,
                              int rdy, int cnt, int busy, int relv, int relrd, int uf, int mm);
    vec_t v;
    v.rst = 1'(r);  v.iv = 1'(iv);  v.ird = 5'(ird);  v.wv = 1'(wv);  v.wrd = 5'(wrd);
    v.fl = 1'(fl);  v.keep = 3'(keep);  v.rdy = 1'(rdy);  v.cnt = 3'(cnt);
    v.busy = 32'(busy);  v.relv = 1'(relv);  v.relrd = 5'(relrd);  v.uf = 1'(uf);  v.mm = 1'(mm);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd, input logic fl, input logic [2:0] keep);
    rst = r; issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd;
    flush = fl; flush_keep = keep;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("issue_ready", idx, 32'(issue_ready), 32'(v.rdy));
    check("count", idx, 32'(count), 32'(v.cnt));
    check("busy_vec", idx, busy_vec, v.busy);
    check("rel_valid", idx, 32'(rel_valid), 32'(v.relv));
    if (v.relv) check("rel_rd", idx, 32'(rel_rd), 32'(v.relrd));
    check("err_underflow", idx, 32'(err_underflow), 32'(v.uf));
    check("err_mismatch", idx, 32'(err_mismatch), 32'(v.mm));
  endtask

  initial begin
    //            rst iv ird wv wrd fl kp | rdy cnt busy    rv rrd uf mm
    vq.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 'h0,     0, 0,  0, 0)); // 0 reset
    vq.push_back(mk(0, 1, 5,  0, 0,  0, 0,  1, 1, 'h20,    0, 0,  0, 0)); // 1
    vq.push_back(mk(0, 1, 7,  0, 0,  0, 0,  1, 2, 'hA0,    0, 0,  0, 0)); // 2
    vq.push_back(mk(0, 0, 0,  1, 5,  0, 0,  1, 1, 'h80,    1, 5,  0, 0)); // 3 release 5
    vq.push_back(mk(0, 0, 0,  1, 7,  0, 0,  1, 0, 'h0,     1, 7,  0, 0)); // 4
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 'h0,     0, 0,  0, 0)); // 5
    vq.push_back(mk(0, 1, 1,  0, 0,  0, 0,  1, 1, 'h2,     0, 0,  0, 0)); // 6 fill
    vq.push_back(mk(0, 1, 2,  0, 0,  0, 0,  1, 2, 'h6,     0, 0,  0, 0)); // 7
    vq.push_back(mk(0, 1, 3,  0, 0,  0, 0,  1, 3, 'hE,     0, 0,  0, 0)); // 8
    vq.push_back(mk(0, 1, 4,  0, 0,  0, 0,  0, 4, 'h1E,    0, 0,  0, 0)); // 9 full
    vq.push_back(mk(0, 1, 11, 0, 0,  0, 0,  0, 4, 'h1E,    0, 0,  0, 0)); // 10 ignored
    vq.push_back(mk(0, 0, 0,  1, 1,  0, 0,  1, 3, 'h1C,    1, 1,  0, 0)); // 11
    vq.push_back(mk(0, 1, 9,  1, 2,  0, 0,  1, 3, 'h218,   1, 2,  0, 0)); // 12 push+pop
    vq.push_back(mk(0, 0, 0,  1, 3,  0, 0,  1, 2, 'h210,   1, 3,  0, 0)); // 13
    vq.push_back(mk(0, 0, 0,  1, 4,  0, 0,  1, 1, 'h200,   1, 4,  0, 0)); // 14
    vq.push_back(mk(0, 0, 0,  1, 9,  0, 0,  1, 0, 'h0,     1, 9,  0, 0)); // 15
    vq.push_back(mk(0, 1, 3,  0, 0,  0, 0,  1, 1, 'h8,     0, 0,  0, 0)); // 16
    vq.push_back(mk(0, 1, 6,  0, 0,  0, 0,  1, 2, 'h48,    0, 0,  0, 0)); // 17
    vq.push_back(mk(0, 1, 8,  0, 0,  0, 0,  1, 3, 'h148,   0, 0,  0, 0)); // 18
    vq.push_back(mk(0, 1, 10, 0, 0,  1, 1,  1, 1, 'h8,     0, 0,  0, 0)); // 19 flush keep 1
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 1, 'h8,     0, 0,  0, 0)); // 20
    vq.push_back(mk(0, 0, 0,  1, 3,  0, 0,  1, 0, 'h0,     1, 3,  0, 0)); // 21
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 'h0,     0, 0,  0, 0)); // 22 no stale rel
    vq.push_back(mk(0, 1, 12, 0, 0,  0, 0,  1, 1, 'h1000,  0, 0,  0, 0)); // 23
    vq.push_back(mk(0, 0, 0,  0, 0,  1, 3,  1, 1, 'h1000,  0, 0,  0, 0)); // 24 keep>=count
    vq.push_back(mk(0, 0, 0,  1, 12, 0, 0,  1, 0, 'h0,     1, 12, 0, 0)); // 25
    vq.push_back(mk(0, 1, 13, 0, 0,  0, 0,  1, 1, 'h2000,  0, 0,  0, 0)); // 26
    vq.push_back(mk(0, 1, 14, 0, 0,  0, 0,  1, 2, 'h6000,  0, 0,  0, 0)); // 27
    vq.push_back(mk(0, 0, 0,  1, 13, 1, 2,  1, 1, 'h4000,  1, 13, 0, 0)); // 28 pop then flush
    vq.push_back(mk(0, 0, 0,  1, 14, 0, 0,  1, 0, 'h0,     1, 14, 0, 0)); // 29
    vq.push_back(mk(0, 1, 5,  0, 0,  0, 0,  1, 1, 'h20,    0, 0,  0, 0)); // 30 duplicate rd
    vq.push_back(mk(0, 1, 5,  0, 0,  0, 0,  1, 2, 'h20,    0, 0,  0, 0)); // 31
    vq.push_back(mk(0, 0, 0,  1, 5,  0, 0,  1, 1, 'h20,    1, 5,  0, 0)); // 32
    vq.push_back(mk(0, 1, 0,  0, 0,  0, 0,  1, 1, 'h20,    0, 0,  0, 0)); // 33 rd 0 dropped
    vq.push_back(mk(0, 0, 0,  1, 5,  0, 0,  1, 0, 'h0,     1, 5,  0, 0)); // 34
    vq.push_back(mk(0, 1, 2,  0, 0,  0, 0,  1, 1, 'h4,     0, 0,  0, 0)); // 35
    vq.push_back(mk(0, 0, 0,  1, 4,  0, 0,  1, 0, 'h0,     1, 2,  0, 1)); // 36 mismatch
    vq.push_back(mk(0, 0, 0,  1, 0,  0, 0,  1, 0, 'h0,     0, 0,  1, 1)); // 37 underflow
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 'h0,     0, 0,  1, 1)); // 38 sticky
    vq.push_back(mk(0, 1, 7,  0, 0,  0, 0,  1, 1, 'h80,    0, 0,  1, 1)); // 39
    vq.push_back(mk(0, 1, 8,  0, 0,  0, 0,  1, 2, 'h180,   0, 0,  1, 1)); // 40
    vq.push_back(mk(0, 1, 9,  0, 0,  0, 0,  1, 3, 'h380,   0, 0,  1, 1)); // 41
    vq.push_back(mk(1, 1, 10, 1, 7,  0, 0,  1, 0, 'h0,     0, 0,  0, 0)); // 42 reset wins
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 'h0,     0, 0,  0, 0)); // 43

    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    flush = 1'b0; flush_keep = '0;
    @(negedge clk);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].iv, vq[i].ird, vq[i].wv, vq[i].wrd, vq[i].fl, vq[i].keep);
      check_all(i, vq[i]);
    end

    // Fill to full across a pointer wrap, flush keeping all, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 5'(20 + k), 1'b0, '0, 1'b0, '0);
      check("fill_count", 100 + k, 32'(count), 32'(k + 1));
    end
    check("full_ready", 104, 32'(issue_ready), 32'd0);
    drive(1'b0, 1'b1, 5'd30, 1'b0, '0, 1'b1, 3'd4);
    check("keep_all_count", 105, 32'(count), 32'd4);
    check("keep_all_busy", 105, busy_vec, 32'h00F0_0000);
    check("keep_all_rel", 105, 32'(rel_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 5'(20 + k), 1'b0, '0);
      check("drain_rel_valid", 110 + k, 32'(rel_valid), 32'd1);
      check("drain_rel_rd", 110 + k, 32'(rel_rd), 32'(20 + k));
      check("drain_count", 110 + k, 32'(count), 32'(3 - k));
    end
    check("drain_busy", 114, busy_vec, 32'h0);
    check("drain_no_err", 114, 32'({err_underflow, err_mismatch}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
